// File: rtl/wall_controller.sv
// rtl/wall_controller.sv - scrolling wall position, random gap, and score FSM for the flappy-style game.
module wall_controller #(
    parameter int SCREEN_W = 160,
    parameter int WALL_W   = 16,
    parameter int GAP_H    = 40,
    parameter int GAP_MIN  = 16,
    parameter int STEP     = 1,
    parameter int GAP_INIT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       touched,
    output logic [7:0] wall_xleft,
    output logic [7:0] wall_xright,
    output logic [7:0] wall_topy,
    output logic [7:0] wall_bottomy,
    output logic [7:0] score,
    output logic       running,
    output logic       game_over
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DEAD = 2'd2;

    localparam logic [7:0] X_INIT   = 8'(SCREEN_W);
    localparam logic [7:0] W_M1     = 8'(WALL_W - 1);
    localparam logic [7:0] GAP_H8   = 8'(GAP_H);
    localparam logic [7:0] GAP_MIN8 = 8'(GAP_MIN);
    localparam logic [7:0] STEP8    = 8'(STEP);
    localparam logic [7:0] TOP_INIT = 8'(GAP_INIT);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // x^8+x^6+x^5+x^4+1 is primitive, so a nonzero seed never reaches zero
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    assign wall_xright  = wall_xleft + W_M1;
    assign wall_bottomy = wall_topy + GAP_H8;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (touched) state_nx = DEAD;
            DEAD:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            running    <= 1'b0;
            game_over  <= 1'b0;
            lfsr       <= 8'hA5;
            wall_xleft <= X_INIT;
            wall_topy  <= TOP_INIT;
            score      <= 8'd0;
        end else begin
            lfsr      <= {lfsr[6:0], lfsr_fb};
            state     <= state_nx;
            running   <= (state_nx == RUN);
            game_over <= (state_nx == DEAD);
            if (state == RUN && !touched && frame_tick) begin
                if (wall_xleft >= STEP8) begin
                    wall_xleft <= wall_xleft - STEP8;
                end else begin
                    wall_xleft <= X_INIT;
                    wall_topy  <= GAP_MIN8 + {2'b00, lfsr[5:0]};
                    if (score != 8'hFF) score <= score + 8'd1;
                end
            end else if (state == DEAD && start) begin
                wall_xleft <= X_INIT;
                wall_topy  <= TOP_INIT;
                score      <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_wall_controller.sv
// tb/tb_wall_controller.sv - directed vector bench for wall_controller.
module tb_wall_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       touched = 1'b0;
    logic [7:0] wall_xleft, wall_xright, wall_topy, wall_bottomy, score;
    logic       running, game_over;

    wall_controller dut (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick), .touched(touched),
        .wall_xleft(wall_xleft), .wall_xright(wall_xright), .wall_topy(wall_topy),
        .wall_bottomy(wall_bottomy), .score(score), .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // reference LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, seed A5
    logic [7:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        string      name;
        logic       s, f, t;
        logic       run, go;
        logic [7:0] x, top, sc;
    } vec_t;

    vec_t vec[14];
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] lfsr_pre;
    logic [7:0] ex, etop, esc;

    task automatic step(input logic s, input logic f, input logic t);
        start = s; frame_tick = f; touched = t;
        lfsr_pre = m_lfsr;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; frame_tick = 1'b0; touched = 1'b0;
    endtask

    task automatic chk(input string name, input logic run, input logic go,
                       input logic [7:0] x, input logic [7:0] top, input logic [7:0] sc);
        logic [7:0] xr, bot;
        xr  = x + 8'd15;
        bot = top + 8'd40;
        n_vec++;
        if (running !== run || game_over !== go || wall_xleft !== x || wall_xright !== xr ||
            wall_topy !== top || wall_bottomy !== bot || score !== sc) begin
            n_err++;
            $display("FAIL %s: got run=%b go=%b xl=%0d xr=%0d top=%0d bot=%0d sc=%0d, want run=%b go=%b xl=%0d xr=%0d top=%0d bot=%0d sc=%0d",
                     name, running, game_over, wall_xleft, wall_xright, wall_topy, wall_bottomy, score,
                     run, go, x, xr, top, bot, sc);
        end
    endtask

    // one frame tick in RUN, with the expected wall state advanced alongside
    task automatic tick();
        step(1'b0, 1'b1, 1'b0);
        if (ex >= 8'd1) begin
            ex = ex - 8'd1;
        end else begin
            ex   = 8'd160;
            etop = 8'd16 + {2'b00, lfsr_pre[5:0]};
            esc  = (esc == 8'd255) ? 8'd255 : esc + 8'd1;
        end
    endtask

    initial begin
        vec[0]  = '{"idle_hold",      0, 0, 0, 0, 0, 8'd160, 8'd40, 8'd0};
        vec[1]  = '{"idle_tick",      0, 1, 0, 0, 0, 8'd160, 8'd40, 8'd0};
        vec[2]  = '{"idle_touch",     0, 0, 1, 0, 0, 8'd160, 8'd40, 8'd0};
        vec[3]  = '{"start",          1, 0, 0, 1, 0, 8'd160, 8'd40, 8'd0};
        vec[4]  = '{"run_start_tick", 1, 1, 0, 1, 0, 8'd159, 8'd40, 8'd0};
        vec[5]  = '{"tick2",          0, 1, 0, 1, 0, 8'd158, 8'd40, 8'd0};
        vec[6]  = '{"tick3",          0, 1, 0, 1, 0, 8'd157, 8'd40, 8'd0};
        vec[7]  = '{"tick4",          0, 1, 0, 1, 0, 8'd156, 8'd40, 8'd0};
        vec[8]  = '{"tick5",          0, 1, 0, 1, 0, 8'd155, 8'd40, 8'd0};
        vec[9]  = '{"run_no_tick",    0, 0, 0, 1, 0, 8'd155, 8'd40, 8'd0};
        vec[10] = '{"touch_and_tick", 0, 1, 1, 0, 1, 8'd155, 8'd40, 8'd0};
        vec[11] = '{"dead_tick",      0, 1, 0, 0, 1, 8'd155, 8'd40, 8'd0};
        vec[12] = '{"dead_touch",     0, 1, 1, 0, 1, 8'd155, 8'd40, 8'd0};
        vec[13] = '{"dead_restart",   1, 0, 0, 1, 0, 8'd160, 8'd40, 8'd0};

        // reset held while inputs are active
        start = 1'b1; frame_tick = 1'b1; touched = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_reset", 0, 0, 8'd160, 8'd40, 8'd0);
        start = 1'b0; frame_tick = 1'b0; touched = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vec[i].s, vec[i].f, vec[i].t);
            chk(vec[i].name, vec[i].run, vec[i].go, vec[i].x, vec[i].top, vec[i].sc);
        end

        // full traverse and first wrap
        ex = 8'd160; etop = 8'd40; esc = 8'd0;
        for (int i = 0; i < 160; i++) tick();
        chk("at_zero", 1, 0, 8'd0, 8'd40, 8'd0);
        tick();
        chk("first_wrap", 1, 0, 8'd160, 8'd16 + {2'b00, lfsr_pre[5:0]}, 8'd1);

        // die on a wrapped wall, then restart; LFSR must keep running
        step(1'b0, 1'b1, 1'b1);
        chk("dead_after_wrap", 0, 1, ex, etop, esc);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        chk("dead_frozen", 0, 1, ex, etop, esc);
        step(1'b1, 1'b0, 1'b0);
        chk("restart", 1, 0, 8'd160, 8'd40, 8'd0);
        ex = 8'd160; etop = 8'd40; esc = 8'd0;
        for (int i = 0; i < 161; i++) tick();
        chk("wrap_after_restart", 1, 0, 8'd160, 8'd16 + {2'b00, lfsr_pre[5:0]}, 8'd1);

        // drive score to saturation and wrap once more
        for (int i = 0; i < 254 * 161; i++) tick();
        chk("score_255", 1, 0, ex, etop, 8'd255);
        for (int i = 0; i < 161; i++) tick();
        chk("score_saturated", 1, 0, 8'd160, 8'd16 + {2'b00, lfsr_pre[5:0]}, 8'd255);

        // asynchronous reset between edges, mid-RUN
        for (int i = 0; i < 7; i++) tick();
        #2 reset = 1'b1;
        #1 chk("async_reset", 0, 0, 8'd160, 8'd40, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("start_after_reset", 1, 0, 8'd160, 8'd40, 8'd0);
        ex = 8'd160; etop = 8'd40; esc = 8'd0;
        for (int i = 0; i < 161; i++) tick();
        chk("wrap_reseeded", 1, 0, 8'd160, 8'd16 + {2'b00, lfsr_pre[5:0]}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
